// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: time-multiplexed N-digit seven-segment scanner with double-buffered glyph/dp/blank inputs
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_DIV     = 50000,
  parameter int DEAD_CYCLES = 2,
  parameter int GLYPH_MODE  = 0,
  parameter int LZB         = 0,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACT_LOW != 0 ? 7'h7f : 7'h00;
  localparam logic DP_OFF = SEG_ACT_LOW != 0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACT_LOW != 0 ? '1 : '0;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*NUM_DIGITS-1:0] pend_dig, act_dig;
  logic [NUM_DIGITS-1:0] pend_dp, act_dp, pend_blank, act_blank, lz;
  logic z, slot_end, wrap, lit, dark;
  logic [3:0] cur;
  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h0: glyph = 7'h3f;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5b;
      4'h3: glyph = 7'h4f;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6d;
      4'h6: glyph = 7'h7d;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7f;
      4'h9: glyph = 7'h6f;
      4'ha: glyph = GLYPH_MODE != 0 ? 7'h77 : 7'h39;
      4'hb: glyph = GLYPH_MODE != 0 ? 7'h7c : 7'h73;
      4'hc: glyph = GLYPH_MODE != 0 ? 7'h39 : 7'h3f;
      4'hd: glyph = GLYPH_MODE != 0 ? 7'h5e : 7'h6f;
      4'he: glyph = GLYPH_MODE != 0 ? 7'h79 : 7'h3e;
      default: glyph = GLYPH_MODE != 0 ? 7'h71 : 7'h50;
    endcase
  endfunction
  always_comb begin
    lz = '0;
    z = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      z = z & (act_dig[4*i +: 4] == 4'd0);
      lz[i] = (LZB != 0) & z;
    end
  end
  assign slot_end = enable && cnt == CW'(CLK_DIV - 1);
  assign wrap = slot_end && idx == IW'(NUM_DIGITS - 1);
  assign lit = enable && cnt >= CW'(DEAD_CYCLES);
  assign cur = act_dig[4*idx +: 4];
  assign dark = act_blank[idx] | lz[idx];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      pend_dig <= '0;
      pend_dp <= '0;
      pend_blank <= '1;
      act_dig <= '0;
      act_dp <= '0;
      act_blank <= '1;
      seg <= SEG_OFF;
      dp <= DP_OFF;
      an <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      if (enable) cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) idx <= wrap ? '0 : idx + IW'(1);
      if (load) begin
        pend_dig <= digits_in;
        pend_dp <= dp_in;
        pend_blank <= blank_in;
      end
      if (wrap) begin
        act_dig <= load ? digits_in : pend_dig;
        act_dp <= load ? dp_in : pend_dp;
        act_blank <= load ? blank_in : pend_blank;
      end
      frame_done <= wrap;
      an <= lit ? AN_OFF ^ (NUM_DIGITS'(1) << idx) : AN_OFF;
      seg <= lit && !dark ? SEG_OFF ^ glyph(cur) : SEG_OFF;
      dp <= DP_OFF ^ (lit && !dark && act_dp[idx]);
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver: directed table-driven check of two driver configurations sharing one stimulus
module tb_sevenseg_scan_driver;
  logic clk = 1'b0, reset, enable, load;
  logic [15:0] digits_in;
  logic [3:0] dp_in, blank_in, an0, an1;
  logic [6:0] seg0, seg1;
  logic dp0, dp1, fd0, fd1;
  int total = 0, bad = 0;
  typedef struct {
    logic [1:0] ld;
    logic [15:0] dig;
    logic [3:0] dpv, blk;
    logic [3:0][6:0] s0, s1;
    logic [3:0] d0, d1;
  } vec_t;
  vec_t tv[8];
  always #5 clk = ~clk;
  sevenseg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(8), .DEAD_CYCLES(2), .GLYPH_MODE(0), .LZB(0),
    .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) u0 (.clk(clk), .reset(reset), .enable(enable), .load(load),
    .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in), .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0));
  sevenseg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(8), .DEAD_CYCLES(2), .GLYPH_MODE(1), .LZB(1),
    .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) u1 (.clk(clk), .reset(reset), .enable(enable), .load(load),
    .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in), .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic check_off();
    chk("off_an0", 8'(an0), 8'h0f);
    chk("off_an1", 8'(an1), 8'h0f);
    chk("off_seg0", 8'(seg0), 8'h7f);
    chk("off_seg1", 8'(seg1), 8'h7f);
    chk("off_dp", {6'd0, dp0, dp1}, 8'h03);
    chk("off_fd", {6'd0, fd0, fd1}, 8'h00);
  endtask
  task automatic check_at(input int v, input int k);
    int slot, c;
    logic [7:0] ea;
    slot = k / 8;
    c = k % 8;
    ea = c < 2 ? 8'h0f : 8'h0f ^ (8'h01 << slot);
    chk("an0", 8'(an0), ea);
    chk("an1", 8'(an1), ea);
    chk("seg0", 8'(seg0), c < 2 ? 8'h7f : 8'(tv[v].s0[slot]));
    chk("seg1", 8'(seg1), c < 2 ? 8'h7f : 8'(tv[v].s1[slot]));
    chk("dp0", 8'(dp0), c < 2 ? 8'h01 : 8'(tv[v].d0[slot]));
    chk("dp1", 8'(dp1), c < 2 ? 8'h01 : 8'(tv[v].d1[slot]));
    chk("frame_done", {6'd0, fd0, fd1}, k == 31 ? 8'h03 : 8'h00);
  endtask
  initial begin
    tv[0] = '{2'd0, 16'h0000, 4'h0, 4'h0, {7'h7f, 7'h7f, 7'h7f, 7'h7f}, {7'h7f, 7'h7f, 7'h7f, 7'h7f}, 4'hf, 4'hf};
    tv[1] = '{2'd1, 16'h1234, 4'h1, 4'h0, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'he, 4'he};
    tv[2] = '{2'd1, 16'hfa09, 4'h8, 4'h2, {7'h2f, 7'h46, 7'h7f, 7'h10}, {7'h0e, 7'h08, 7'h7f, 7'h10}, 4'h7, 4'h7};
    tv[3] = '{2'd1, 16'h0050, 4'h0, 4'h0, {7'h40, 7'h40, 7'h12, 7'h40}, {7'h7f, 7'h7f, 7'h12, 7'h40}, 4'hf, 4'hf};
    tv[4] = '{2'd1, 16'h0000, 4'hd, 4'h0, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7f, 7'h7f, 7'h7f, 7'h40}, 4'h2, 4'he};
    tv[5] = '{2'd2, 16'haaaa, 4'h0, 4'h0, {7'h46, 7'h46, 7'h46, 7'h46}, {7'h08, 7'h08, 7'h08, 7'h08}, 4'hf, 4'hf};
    tv[6] = '{2'd1, 16'hbcde, 4'h4, 4'h8, {7'h7f, 7'h40, 7'h10, 7'h41}, {7'h7f, 7'h46, 7'h21, 7'h06}, 4'hb, 4'hb};
    tv[7] = '{2'd2, 16'h7863, 4'h3, 4'h0, {7'h78, 7'h00, 7'h02, 7'h30}, {7'h78, 7'h00, 7'h02, 7'h30}, 4'hc, 4'hc};
    reset = 1'b1;
    enable = 1'b1;
    load = 1'b0;
    digits_in = '0;
    dp_in = '0;
    blank_in = '0;
    #1;
    check_off();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    digits_in = 16'h1234;
    dp_in = 4'h1;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (4) tick();
    chk("pre_rst_an0", 8'(an0), 8'h0e);
    chk("pre_rst_seg0", 8'(seg0), 8'h7f);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_off();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int v = 0; v < 8; v++)
      for (int k = 0; k < 32; k++) begin
        load = 1'b0;
        if (v < 7 && ((k == 10 && tv[v+1].ld == 2'd2) || (k == 31 && tv[v+1].ld == 2'd1))) begin
          digits_in = tv[v+1].dig;
          dp_in = tv[v+1].dpv;
          blank_in = tv[v+1].blk;
          load = 1'b1;
        end
        tick();
        check_at(v, k);
      end
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_at(7, k);
    end
    enable = 1'b0;
    repeat (20) begin
      tick();
      check_off();
    end
    enable = 1'b1;
    for (int k = 4; k < 32; k++) begin
      tick();
      check_at(7, k);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
